// File: rtl/onewire_pkg.sv
// onewire_pkg: shared types and tick constants for the 1-wire master.
// Tick = TS/8 normal, TS/64 overdrive; all constants are in ticks.
package onewire_pkg;

    typedef enum logic [1:0] {
        CMD_RST  = 2'd0,
        CMD_BIT  = 2'd1,
        CMD_BYTE = 2'd2
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        RST_LOW,
        RST_PRS,
        DAT_LOW,
        DAT_REC
    } state_t;

    localparam logic [7:0] T_RST_LOW = 8'd80;
    localparam logic [7:0] T_PRS_SMP = 8'd104;
    localparam logic [7:0] T_RST_END = 8'd144;
    localparam logic [7:0] T_W0_LOW  = 8'd12;
    localparam logic [7:0] T_W1_LOW  = 8'd1;
    localparam logic [7:0] T_RD_SMP  = 8'd6;
    localparam logic [7:0] T_SLOT    = 8'd16;

    // Index of the last tick of a phase lasting len ticks
    function automatic logic [7:0] last_tick(input logic [7:0] len);
        return len - 8'd1;
    endfunction

endpackage

// File: rtl/onewire_clkdiv.sv
// onewire_clkdiv: one-cycle tick pulse every CDR_N or CDR_O clocks.
// clr restarts the count so the next tick lands a full period later.
module onewire_clkdiv #(
    parameter int CDR_N = 30,
    parameter int CDR_O = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic ovd,
    output logic tick
);

    localparam int CMAX = (CDR_N > CDR_O) ? CDR_N : CDR_O;
    localparam int W    = $clog2(CMAX) + 1;

    logic [W-1:0] cnt;
    logic [W-1:0] lim;

    assign lim  = ovd ? W'(CDR_O - 1) : W'(CDR_N - 1);
    assign tick = (cnt == lim);

    // Free-running divider, wrapped on tick, restarted on clear
    always_ff @(posedge clk) begin
        if (rst || clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/onewire_master.sv
// onewire_master: 1-wire reset/bit/byte sequencer with open-drain drive.
// Optional strong pull-up output enabled by defining ONEWIRE_PWR_EN.
module onewire_master
    import onewire_pkg::*;
#(
    parameter int CDR_N = 30,
    parameter int CDR_O = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_vld,
    output logic       req_rdy,
    input  logic [1:0] req_cmd,
    input  logic       req_ovd,
    input  logic [7:0] req_dat,
    output logic       rsp_vld,
    output logic [7:0] rsp_dat,
    output logic       rsp_prs,
    output logic       rsp_err,
    output logic       owr_e,
`ifdef ONEWIRE_PWR_EN
    input  logic       req_pwr,
    output logic       owr_p,
`endif
    input  logic       owr_i
);

    state_t     state;
    state_t     nxt;
    cmd_t       cmd_q;
    logic       ovd_q;
    logic [7:0] dat_q;
    logic [7:0] tcnt;
    logic [2:0] bit_idx;
    logic [7:0] sh;
    logic       prs_q;
    logic       err_q;
    logic       owr_s1;
    logic       owr_s2;
    logic       tick;
    logic       accept;
    logic       done;
    logic       cur_bit;
    logic [7:0] low_len;
    logic       last_bit;
    logic       slot_end;
    logic       rst_end;

    assign req_rdy  = (state == IDLE) && !rsp_vld;
    assign accept   = req_vld && req_rdy;
    assign cur_bit  = dat_q[bit_idx];
    assign low_len  = cur_bit ? T_W1_LOW : T_W0_LOW;
    assign last_bit = (cmd_q == CMD_BYTE) ? (bit_idx == 3'd7) : 1'b1;
    assign slot_end = tick && (tcnt == last_tick(T_SLOT));
    assign rst_end  = tick && (tcnt == last_tick(T_RST_END));

    onewire_clkdiv #(
        .CDR_N (CDR_N),
        .CDR_O (CDR_O)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .ovd  (ovd_q),
        .tick (tick)
    );

    // Two-flop synchronizer for the asynchronous bus level
    always_ff @(posedge clk) begin
        if (rst) begin
            owr_s1 <= 1'b1;
            owr_s2 <= 1'b1;
        end else begin
            owr_s1 <= owr_i;
            owr_s2 <= owr_s1;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    // Next state, bus drive and completion strobe
    always_comb begin
        nxt   = state;
        owr_e = 1'b0;
        done  = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    nxt = (req_cmd == CMD_RST) ? RST_LOW : DAT_LOW;
                end
            end
            RST_LOW: begin
                owr_e = 1'b1;
                if (tick && (tcnt == last_tick(T_RST_LOW))) begin
                    nxt = RST_PRS;
                end
            end
            RST_PRS: begin
                if (rst_end) begin
                    nxt  = IDLE;
                    done = 1'b1;
                end
            end
            DAT_LOW: begin
                owr_e = 1'b1;
                if (tick && (tcnt == last_tick(low_len))) begin
                    nxt = DAT_REC;
                end
            end
            DAT_REC: begin
                if (slot_end) begin
                    done = last_bit;
                    nxt  = last_bit ? IDLE : DAT_LOW;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    // Command latch, tick counting, bus sampling and response
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q   <= CMD_RST;
            ovd_q   <= 1'b0;
            dat_q   <= 8'd0;
            tcnt    <= 8'd0;
            bit_idx <= 3'd0;
            sh      <= 8'd0;
            prs_q   <= 1'b0;
            err_q   <= 1'b0;
            rsp_vld <= 1'b0;
            rsp_dat <= 8'd0;
            rsp_prs <= 1'b0;
            rsp_err <= 1'b0;
        end else begin
            rsp_vld <= done;
            if (accept) begin
                cmd_q   <= cmd_t'(req_cmd);
                ovd_q   <= req_ovd;
                dat_q   <= req_dat;
                tcnt    <= 8'd0;
                bit_idx <= 3'd0;
                sh      <= 8'd0;
                prs_q   <= 1'b0;
                err_q   <= 1'b0;
            end else begin
                if (tick) begin
                    tcnt <= tcnt + 8'd1;
                end
                if (state == DAT_REC && slot_end && !last_bit) begin
                    tcnt    <= 8'd0;
                    bit_idx <= bit_idx + 3'd1;
                end
                if (state == RST_PRS && tick && tcnt == T_PRS_SMP) begin
                    prs_q <= ~owr_s2;
                end
                if ((state == DAT_LOW || state == DAT_REC)
                    && tick && tcnt == T_RD_SMP) begin
                    sh[bit_idx] <= owr_s2;
                end
                if ((state == RST_PRS && rst_end)
                    || (state == DAT_REC && slot_end)) begin
                    err_q <= err_q | ~owr_s2;
                end
            end
            if (done) begin
                rsp_dat <= sh;
                rsp_prs <= prs_q;
                rsp_err <= err_q | ~owr_s2;
            end
        end
    end

`ifdef ONEWIRE_PWR_EN
    logic pwr_q;

    // Strong pull-up from completion until the next command starts
    always_ff @(posedge clk) begin
        if (rst) begin
            pwr_q <= 1'b0;
            owr_p <= 1'b0;
        end else if (accept) begin
            pwr_q <= req_pwr;
            owr_p <= 1'b0;
        end else if (done && pwr_q) begin
            owr_p <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_onewire_master.sv
// tb_onewire_master: onewire_master with a behavioural slave on a pulled-up bus.
// Vector table plus scoreboard; hand sequences for mid-command reset.
`timescale 1ns/1ps
module tb_onewire_master;
    import onewire_pkg::*;

    localparam int CDR_N = 30;
    localparam int CDR_O = 4;

    typedef struct {
        logic [1:0] cmd;
        logic       ovd;
        logic [7:0] dat;
        logic       en;
        logic [7:0] tx;
        logic       frc;
        logic [7:0] e_dat;
        logic       e_prs;
        logic       e_err;
        int         e_low;
        int         e_lat;
        logic       crx;
        logic [7:0] e_rx;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_vld = 1'b0;
    logic       req_rdy;
    logic [1:0] req_cmd = 2'd0;
    logic       req_ovd = 1'b0;
    logic [7:0] req_dat = 8'd0;
    logic       rsp_vld;
    logic [7:0] rsp_dat;
    logic       rsp_prs;
    logic       rsp_err;
    logic       owr_e;
`ifdef ONEWIRE_PWR_EN
    logic       req_pwr = 1'b0;
    logic       owr_p;
`endif

    logic       slv_pull = 1'b0;
    logic       force_lo = 1'b0;
    logic       slv_en = 1'b0;
    logic       cur_ovd = 1'b0;
    logic [7:0] slv_tx = 8'd0;
    logic [7:0] slv_rx = 8'd0;
    logic [2:0] slv_idx = 3'd0;
    logic       owr_prev = 1'b1;
    logic       active = 1'b0;
    logic       is_rst = 1'b0;
    logic       cur_bit = 1'b1;
    int         since = 0;
    int         tl;

    int   n_chk = 0;
    int   n_err = 0;
    int   n_rsp = 0;
    int   lat = 0;
    int   lowc = 0;
    vec_t sb[$];
    vec_t e;
    vec_t vt[10];

    wire owr   = ~(owr_e | slv_pull | force_lo);
    wire owr_m = ~(owr_e | force_lo);

    always #5 clk = ~clk;

    onewire_master #(
        .CDR_N (CDR_N),
        .CDR_O (CDR_O)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req_vld (req_vld),
        .req_rdy (req_rdy),
        .req_cmd (req_cmd),
        .req_ovd (req_ovd),
        .req_dat (req_dat),
        .rsp_vld (rsp_vld),
        .rsp_dat (rsp_dat),
        .rsp_prs (rsp_prs),
        .rsp_err (rsp_err),
        .owr_e   (owr_e),
`ifdef ONEWIRE_PWR_EN
        .req_pwr (req_pwr),
        .owr_p   (owr_p),
`endif
        .owr_i   (owr)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     nm, act, act, exp, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic [1:0] cmd, input logic ovd, input logic [7:0] dat,
        input logic en, input logic [7:0] tx, input logic frc,
        input logic [7:0] ed, input logic ep, input logic ee,
        input int el, input int elat, input logic crx, input logic [7:0] erx);
        vec_t v;
        v.cmd = cmd; v.ovd = ovd; v.dat = dat; v.en = en; v.tx = tx;
        v.frc = frc; v.e_dat = ed; v.e_prs = ep; v.e_err = ee;
        v.e_low = el; v.e_lat = elat; v.crx = crx; v.e_rx = erx;
        return v;
    endfunction

    always_comb tl = cur_ovd ? CDR_O : CDR_N;

    // Slave model: slot timing measured from each master-made falling edge
    always @(posedge clk) begin
        owr_prev <= owr;
        if (owr_prev && !owr && !slv_pull) begin
            since   <= 1;
            active  <= 1'b1;
            is_rst  <= 1'b0;
            cur_bit <= slv_tx[slv_idx];
            slv_idx <= slv_idx + 3'd1;
        end else if (active) begin
            since <= since + 1;
        end
        if (active && !is_rst && since == 4 * tl) begin
            slv_rx <= {owr_m, slv_rx[7:1]};
        end
        if (active && since == 40 * tl && !owr_m) begin
            is_rst  <= 1'b1;
            slv_idx <= 3'd0;
        end
        slv_pull <= slv_en && active &&
                    (is_rst ? (since >= 88 * tl && since < 120 * tl)
                            : (since < 8 * tl && !cur_bit));
    end

    // Latency and low-time counters, restarted at each accept
    always @(posedge clk) begin
        if (req_vld && req_rdy) begin
            lat  <= 0;
            lowc <= 0;
        end else begin
            lat <= lat + 1;
            if (owr_e) lowc <= lowc + 1;
        end
    end

    // Scoreboard check on each response pulse
    always @(negedge clk) begin
        if (!rst && rsp_vld) begin
            n_rsp++;
            chk("sb_nonempty", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("rsp_dat", int'(rsp_dat), int'(e.e_dat));
                chk("rsp_prs", int'(rsp_prs), int'(e.e_prs));
                chk("rsp_err", int'(rsp_err), int'(e.e_err));
                chk("rsp_lat", lat, e.e_lat);
                chk("owr_low_clks", lowc, e.e_low);
                chk("rdy_in_rsp", int'(req_rdy), 0);
                if (e.crx) chk("slv_rx", int'(slv_rx), int'(e.e_rx));
            end
        end
    end

    task automatic issue(input vec_t v);
        @(negedge clk);
        slv_en   = v.en;
        slv_tx   = v.tx;
        force_lo = v.frc;
        cur_ovd  = v.ovd;
        req_cmd  = v.cmd;
        req_ovd  = v.ovd;
        req_dat  = v.dat;
        req_vld  = 1'b1;
        sb.push_back(v);
        @(posedge clk);
        #1 req_vld = 1'b0;
    endtask

    task automatic wait_rsp();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 6000 && !got; i++) begin
            @(negedge clk);
            if (rsp_vld) got = 1'b1;
        end
        chk("rsp_seen", int'(got), 1);
        if (got) begin
            @(negedge clk);
            chk("rdy_after_rsp", int'(req_rdy), 1);
        end
        force_lo = 1'b0;
    endtask

    initial begin
        int n0;
        vec_t v;
        vt[0] = mk(CMD_RST, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b0,
                   8'h00, 1'b1, 1'b0, 80 * CDR_N, 144 * CDR_N, 1'b0, 8'h00);
        vt[1] = mk(CMD_RST, 1'b0, 8'h00, 1'b0, 8'hFF, 1'b0,
                   8'h00, 1'b0, 1'b0, 80 * CDR_N, 144 * CDR_N, 1'b0, 8'h00);
        vt[2] = mk(CMD_RST, 1'b0, 8'h00, 1'b0, 8'hFF, 1'b1,
                   8'h00, 1'b1, 1'b1, 80 * CDR_N, 144 * CDR_N, 1'b0, 8'h00);
        vt[3] = mk(CMD_RST, 1'b0, 8'h00, 1'b1, 8'h3C, 1'b0,
                   8'h00, 1'b1, 1'b0, 80 * CDR_N, 144 * CDR_N, 1'b0, 8'h00);
        vt[4] = mk(CMD_BYTE, 1'b0, 8'hA5, 1'b1, 8'h3C, 1'b0,
                   8'h24, 1'b0, 1'b0, 52 * CDR_N, 128 * CDR_N, 1'b1, 8'hA5);
        vt[5] = mk(CMD_BIT, 1'b1, 8'h01, 1'b1, 8'hFF, 1'b0,
                   8'h01, 1'b0, 1'b0, 1 * CDR_O, 16 * CDR_O, 1'b0, 8'h00);
        vt[6] = mk(CMD_BIT, 1'b0, 8'h01, 1'b1, 8'h00, 1'b0,
                   8'h00, 1'b0, 1'b0, 1 * CDR_N, 16 * CDR_N, 1'b0, 8'h00);
        vt[7] = mk(CMD_BIT, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b0,
                   8'h00, 1'b0, 1'b0, 12 * CDR_N, 16 * CDR_N, 1'b0, 8'h00);
        vt[8] = mk(CMD_BYTE, 1'b1, 8'hFF, 1'b1, 8'hFF, 1'b0,
                   8'hFF, 1'b0, 1'b0, 8 * CDR_O, 128 * CDR_O, 1'b1, 8'hFF);
        vt[9] = mk(CMD_BIT, 1'b1, 8'h01, 1'b0, 8'hFF, 1'b1,
                   8'h00, 1'b0, 1'b1, 1 * CDR_O, 16 * CDR_O, 1'b0, 8'h00);

        repeat (4) @(negedge clk);
        chk("rst_req_rdy", int'(req_rdy), 1);
        chk("rst_rsp_vld", int'(rsp_vld), 0);
        chk("rst_rsp_dat", int'(rsp_dat), 0);
        chk("rst_rsp_prs", int'(rsp_prs), 0);
        chk("rst_rsp_err", int'(rsp_err), 0);
        chk("rst_owr_e", int'(owr_e), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            issue(vt[i]);
            wait_rsp();
        end

        v = mk(CMD_BYTE, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b0,
               8'h00, 1'b0, 1'b0, 0, 0, 1'b0, 8'h00);
        issue(v);
        repeat (500) @(negedge clk);
        chk("busy_rdy", int'(req_rdy), 0);
        chk("busy_owr_e", int'(owr_e), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_owr_e", int'(owr_e), 0);
        chk("midrst_rdy", int'(req_rdy), 1);
        chk("midrst_rsp_vld", int'(rsp_vld), 0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n0 = n_rsp;
        repeat (4000) @(negedge clk);
        chk("no_rsp_after_rst", n_rsp, n0);
        issue(vt[0]);
        wait_rsp();

`ifdef ONEWIRE_PWR_EN
        req_pwr = 1'b1;
        issue(vt[8]);
        wait_rsp();
        chk("owr_p_set", int'(owr_p), 1);
        req_pwr = 1'b0;
        issue(vt[5]);
        chk("owr_p_clr", int'(owr_p), 0);
        wait_rsp();
        chk("owr_p_stays_clr", int'(owr_p), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
